// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encodings and FSM state type shared by the multi-cycle ALU
package alu_pkg;

   // Base ops: {funct7[5], funct3}
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   // Mul/div ops: funct3
   localparam logic [2:0] MD_MUL   = 3'b000;
   localparam logic [2:0] MD_MULHU = 3'b011;
   localparam logic [2:0] MD_DIV   = 3'b100;
   localparam logic [2:0] MD_DIVU  = 3'b101;
   localparam logic [2:0] MD_REM   = 3'b110;
   localparam logic [2:0] MD_REMU  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative shift-add multiplier and restoring divider
// One bit per cycle; done and result are valid in the cycle of the last iteration.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       funct3,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] IDLE_CNT = CW'(WIDTH);

   // acc holds {hi, lo} for multiply and {remainder, quotient} for divide
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [2*WIDTH-1:0] mul_nxt;
   logic [2*WIDTH-1:0] div_nxt;
   logic [WIDTH-1:0]   opb;
   logic [2:0]         f3;
   logic               neg_q;
   logic               neg_r;
   logic [CW-1:0]      cnt;

   logic               is_signed;
   logic               sa;
   logic               sb;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;

   assign is_signed = (funct3 == MD_DIV) || (funct3 == MD_REM);
   assign sa        = is_signed & a[WIDTH-1];
   assign sb        = is_signed & b[WIDTH-1];
   assign a_mag     = sa ? -a : a;
   assign b_mag     = sb ? -b : b;

   always_comb begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      mul_nxt = {sum, acc[WIDTH-1:1]};
      shifted = acc[2*WIDTH-1:WIDTH-1];
      diff    = shifted - {1'b0, opb};
      if (diff[WIDTH])
         div_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      acc_nxt = f3[2] ? div_nxt : mul_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         opb   <= '0;
         f3    <= MD_MUL;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         cnt   <= IDLE_CNT;
      end else if (start) begin
         f3    <= funct3;
         cnt   <= '0;
         neg_r <= sa;
         // A zero divisor keeps the all-ones quotient unsigned-looking
         neg_q <= (sa ^ sb) && (b != '0);
         if (funct3[2]) begin
            acc <= {{WIDTH{1'b0}}, a_mag};
            opb <= b_mag;
         end else begin
            acc <= {{WIDTH{1'b0}}, b};
            opb <= a;
         end
      end else if (cnt != IDLE_CNT) begin
         acc <= acc_nxt;
         cnt <= cnt + CW'(1);
      end
   end

   assign done = (cnt == LAST_CNT);

   always_comb begin
      result = '0;
      case (f3)
         MD_MUL:           result = acc_nxt[WIDTH-1:0];
         MD_MULHU:         result = acc_nxt[2*WIDTH-1:WIDTH];
         MD_DIV, MD_DIVU:  result = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
         MD_REM, MD_REMU:  result = neg_r ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
         default:          result = '0;
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle execute-stage ALU with valid/ready on both sides
// Base ops register in one cycle; mul/div run through alu_muldiv.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic             md,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             start;
   logic             load_base;
   logic             load_md;
   logic             md_done;
   logic [WIDTH-1:0] md_res;
   logic [WIDTH-1:0] base_res;
   logic [SHW-1:0]   shamt;

   assign shamt = b[SHW-1:0];

   always_comb begin
      base_res = '0;
      case (op)
         ALU_ADD:  base_res = a + b;
         ALU_SUB:  base_res = a - b;
         ALU_SLL:  base_res = a << shamt;
         ALU_SRL:  base_res = a >> shamt;
         ALU_SRA:  base_res = $signed(a) >>> shamt;
         ALU_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: base_res = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_XOR:  base_res = a ^ b;
         ALU_OR:   base_res = a | b;
         ALU_AND:  base_res = a & b;
         default:  base_res = '0;
      endcase
   end

   alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .funct3 (op[2:0]),
      .done   (md_done),
      .result (md_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = md ? CALC : DONE;
         CALC: if (md_done) state_nxt = DONE;
         DONE: begin
            if (accept)
               state_nxt = md ? CALC : DONE;
            else if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // DONE re-opens the input only when the result leaves in the same edge
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
   end

   assign accept    = in_valid & in_ready;
   assign start     = accept & md;
   assign load_base = accept & ~md;
   assign load_md   = (state == CALC) & md_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out  <= '0;
         zero <= 1'b1;
      end else if (load_base) begin
         out  <= base_res;
         zero <= (base_res == '0);
      end else if (load_md) begin
         out  <= md_res;
         zero <= (md_res == '0);
      end
   end

endmodule
